// File: rtl/fifo_pkt_pkg.sv
// Shared types and sizing constants for the packet framer.
package fifo_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    POP  = 3'd2,
    WAIT = 3'd3,
    HOLD = 3'd4
  } state_t;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_PKT_LEN = 4;
  localparam int PKT_LEN_MAX     = 255;

endpackage

// File: rtl/fifo_pkt_framer_slot.sv
// Single-entry valid/ready holding register feeding the framed output port.
module pkt_out_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  output logic             accept
);

  assign accept = m_valid && m_ready;

  // The framer only loads when the slot is empty, so load never overwrites a pending word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_data  <= load_data;
      m_valid <= 1'b1;
      m_last  <= load_last;
    end else if (accept) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_pkt_framer.sv
// Frames words popped from an upstream queue into header + PKT_LEN payload packets.
//   state | meaning
//   IDLE  | waiting for source data to start a packet
//   HDR   | header word held in the output slot
//   POP   | waiting for source data, then one-cycle pop pulse
//   WAIT  | popped word arriving, captured into the slot this edge
//   HOLD  | payload word held in the output slot
module fifo_pkt_framer
  import fifo_pkt_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int PKT_LEN = DEFAULT_PKT_LEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] src_data,
  input  logic             src_empty,
  output logic             src_rd_en,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last
);

  localparam int CNT_W = $clog2(PKT_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_LEN - 1);

  state_t           state;
  logic [WIDTH-1:0] seq;
  logic [CNT_W-1:0] cnt;
  logic             start;
  logic             load;
  logic             load_last;
  logic [WIDTH-1:0] load_data;
  logic             accept;

  assign start = (state == IDLE) && !src_empty && !m_valid;

  always_comb begin
    load      = start || (state == WAIT);
    load_data = (state == WAIT) ? src_data : seq;
    load_last = (state == WAIT) && (cnt == LAST_IDX);
  end

  // src_rd_en is a registered pulse; the POP cycle that carries it moves to WAIT,
  // which guarantees an idle cycle between pops and keeps it off m_ready/src_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      seq       <= '0;
      cnt       <= '0;
      src_rd_en <= 1'b0;
    end else begin
      src_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) state <= HDR;
        end
        HDR: begin
          if (accept) state <= POP;
        end
        POP: begin
          if (src_rd_en)       state     <= WAIT;
          else if (!src_empty) src_rd_en <= 1'b1;
        end
        WAIT: begin
          state <= HOLD;
        end
        HOLD: begin
          if (accept) begin
            if (cnt == LAST_IDX) begin
              cnt   <= '0;
              seq   <= seq + WIDTH'(1);
              state <= IDLE;
            end else begin
              cnt   <= cnt + CNT_W'(1);
              state <= POP;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  pkt_out_slot #(.WIDTH(WIDTH)) u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .load_last (load_last),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .accept    (accept)
  );

endmodule

// File: tb/tb_fifo_pkt_framer.sv
// Scoreboard bench: a queue-backed upstream model feeds the framer, expected packets are queued on push.
module tb_fifo_pkt_framer;

  localparam int WIDTH   = 8;
  localparam int PKT_LEN = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] src_data;
  logic             src_empty;
  logic             src_rd_en;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  fifo_pkt_framer #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_data  (src_data),
    .src_empty (src_empty),
    .src_rd_en (src_rd_en),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] src_q[$];
  logic [WIDTH:0]   exp_q[$];
  int               widx  = 0;
  logic [WIDTH-1:0] seq_m = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Each packet is a header followed by the next PKT_LEN source words in order.
  task automatic src_push(input logic [WIDTH-1:0] w);
    src_q.push_back(w);
    if (widx == 0) exp_q.push_back({1'b0, seq_m});
    exp_q.push_back({(widx == PKT_LEN - 1), w});
    widx = (widx + 1) % PKT_LEN;
    if (widx == 0) seq_m = seq_m + 1'b1;
  endtask

  task automatic model_flush();
    src_q.delete();
    exp_q.delete();
    widx  = 0;
    seq_m = '0;
  endtask

  // Upstream queue model: pop on rd_en, data and empty flag registered.
  logic pop_req = 1'b0;
  always @(negedge clk) pop_req = src_rd_en;
  always @(posedge clk) begin
    #1;
    if (pop_req && src_q.size() > 0) src_data = src_q.pop_front();
    src_empty = (src_q.size() == 0);
  end

  logic             prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0, prev_rd = 1'b0;
  logic [WIDTH-1:0] prev_d = '0;
  logic [WIDTH:0]   e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v  = 1'b0;
      prev_rd = 1'b0;
    end else begin
      if (prev_v && !prev_r)
        chk("hold_stable", {m_valid, m_last, m_data}, {1'b1, prev_l, prev_d});
      if (src_rd_en)
        chk("pop_legal", {prev_rd, (src_q.size() == 0)}, 0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {m_last, m_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("out_word", {m_last, m_data}, e);
        end
      end
      prev_v  = m_valid;
      prev_r  = m_ready;
      prev_d  = m_data;
      prev_l  = m_last;
      prev_rd = src_rd_en;
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #2 model_flush();
    @(negedge clk);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    chk("rst_rd_en", src_rd_en, 0);
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    m_ready   = 1'b0;
    src_empty = 1'b1;
    src_data  = '0;

    // Reset held with data waiting upstream: nothing may move.
    @(negedge clk);
    for (int i = 1; i <= 4; i++) src_push(8'hA0 + 8'(i));
    repeat (3) begin
      @(negedge clk);
      chk("init_rd_en", src_rd_en, 0);
      chk("init_valid", m_valid, 0);
      chk("init_data", m_data, 0);
    end
    rst_n   = 1'b1;
    m_ready = 1'b1;
    wait_drain(200);

    // Second packet carries header 0x01.
    for (int i = 1; i <= 4; i++) src_push(8'hB0 + 8'(i));
    wait_drain(200);

    // Backpressure on payload word 0xA2.
    for (int i = 1; i <= 4; i++) src_push(8'hA0 + 8'(i));
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(m_valid && m_data == 8'hA2) && n < 200);
    chk("bp_found", (m_valid && m_data == 8'hA2), 1);
    m_ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold", {m_valid, m_data, src_rd_en}, {1'b1, 8'hA2, 1'b0});
    end
    @(posedge clk); #1 m_ready = 1'b1;
    wait_drain(200);

    // Starvation after two payload words.
    src_push(8'hD1);
    src_push(8'hD2);
    wait_drain(200);
    repeat (6) begin
      @(negedge clk);
      chk("starve_idle", {m_valid, src_rd_en}, 0);
    end
    src_push(8'hD3);
    src_push(8'hD4);
    wait_drain(200);

    // Reset after payload word 2, then the next header restarts at 0.
    for (int i = 1; i <= 4; i++) src_push(8'hE0 + 8'(i));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_valid && m_ready && m_data == 8'hE2) && n < 200);
    chk("mid_found", (m_valid && m_ready && m_data == 8'hE2), 1);
    do_reset();
    for (int i = 1; i <= 4; i++) src_push(8'hF0 + 8'(i));
    wait_drain(200);

    // 257 packets with random data, random source gaps and random backpressure.
    do_reset();
    begin
      int pushed = 0;
      while (pushed < 257 * PKT_LEN) begin
        @(posedge clk); #1 m_ready = ($urandom_range(3, 0) != 0);
        @(negedge clk);
        if ($urandom_range(1, 0) == 1) begin
          src_push(8'($urandom));
          pushed++;
        end
      end
    end
    @(posedge clk); #1 m_ready = 1'b1;
    wait_drain(20000);
    chk("wrap_seq", seq_m, 8'h01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_pkt_framer.md
FIFO_PKT_FRAMER -- requirements
Module: fifo_pkt_framer

Interface
REQ-001 Parameter: WIDTH, default 8, width of source words and output words.
REQ-002 Parameter: PKT_LEN, default 4, payload words per packet (legal range 1..255).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 src_data  input  WIDTH  upstream queue read data, valid one cycle after a pop.
REQ-006 src_empty  input  1  upstream queue empty flag, registered upstream.
REQ-007 src_rd_en  output  1  pop request to upstream queue, one cycle high per pop.
REQ-008 m_data  output  WIDTH  framed output word.
REQ-009 m_valid  output  1  m_data/m_last valid.
REQ-010 m_ready  input  1  downstream accepts the word when m_valid and m_ready are both high at a rising edge.
REQ-011 m_last  output  1  marks the final payload word of a packet.

Function
REQ-012 Each packet is 1 header word followed by PKT_LEN payload words, in that order, never interleaved.
REQ-013 Header word equals the packet sequence counter seq (WIDTH bits), zero-extended or truncated to WIDTH; seq increments by 1 after the packet's last word is accepted and wraps modulo 2^WIDTH.
REQ-014 FSM states are IDLE, HDR, POP, WAIT, HOLD.
  - IDLE: when src_empty=0 and the output slot is empty -> load header into the slot, go to HDR.
  - HDR/HOLD: hold the slot until accepted.
  - After acceptance -> POP if payload words remain, else IDLE.
  - POP: if src_empty=0, assert src_rd_en for 1 cycle -> WAIT.
  - WAIT: capture src_data into the slot on the next edge -> HOLD.
REQ-015 Pop latency: src_data is captured exactly 1 cycle after the cycle in which src_rd_en was high.
REQ-016 src_rd_en is decoded from registered state only, with no combinational path from m_ready or src_data.
REQ-017 At least one cycle with src_rd_en=0 separates any two pops, so that the registered src_empty has settled before it is sampled again.
REQ-018 src_rd_en is asserted only when src_empty=0 and the output slot is empty or will be empty at capture; a pop is never issued while a captured word is unaccepted.
REQ-019 While m_valid=1 and m_ready=0, m_data, m_last and m_valid hold stable.
REQ-020 m_last=1 only on payload word PKT_LEN; it is 0 on the header word and on all other payload words.
REQ-021 If src_empty=1 mid-packet, the block stalls in POP with m_valid=0 and no word is duplicated or dropped; it resumes when src_empty=0.
REQ-022 A payload counter of width $clog2(PKT_LEN+1) counts payload words accepted; it clears on entry to IDLE.
REQ-023 The block emits a header only when src_empty=0 in IDLE; no empty packets are ever started.

Reset
REQ-024 On rst_n=0 at a rising edge, the block resets to:
  - m_valid=0, m_data=0, m_last=0, src_rd_en=0;
  - seq=0, payload counter=0, state=IDLE.
REQ-025 Reset mid-packet abandons the packet; the next header after reset is 0; a source word popped before reset is discarded.

Structure
REQ-026 Package fifo_pkt_pkg holds the FSM state enum and the header/sequence width constants.
REQ-027 One sub-module, pkt_out_slot, is the single-entry valid/ready holding register driving m_data/m_valid/m_last.

Verification
REQ-028 Reset: hold rst_n=0 for 2 cycles with src_empty=0 -> src_rd_en=0, m_valid=0, m_data=0 throughout.
REQ-029 Basic packet: PKT_LEN=4, source holds 0xA1..0xA4, m_ready=1 -> outputs 0x00, 0xA1, 0xA2, 0xA3, 0xA4, with m_last only on 0xA4; the next header is 0x01.
REQ-030 Backpressure: m_ready=0 for 10 cycles while m_valid=1 on 0xA2 -> m_data stays 0xA2, src_rd_en stays 0, and no word is lost after release.
REQ-031 Starvation: src_empty=1 after 2 payload words for 6 cycles -> m_valid=0 and no pops; after refill the remaining 2 words follow with m_last on the 4th.
REQ-032 Wrap: 257 back-to-back packets -> headers run 0x00..0xFF then 0x00; no pops are issued on adjacent cycles.
REQ-033 Reset mid-packet: assert rst_n=0 after payload word 2 -> all outputs clear; after release the next packet begins with header 0x00.
